seq_alu: RTL and testbench

SEQ_ALU -- requirements
Module: seq_alu

---
 rtl/seq_alu.sv | 210 +++++++++++++++++++++
 tb/tb_seq_alu.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// seq_alu: sequential integer ALU with ready/valid handshake on both sides.
// Single-cycle ops (add/sub/logic/shift/compare, load/store address, branch
// compare) return one edge after acceptance. Multiply and divide/remainder run
// iteratively, one bit per cycle for WIDTH cycles, on operand magnitudes with a
// sign fix-up folded into the last iteration edge.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   in_valid/in_ready    operation handshake (itype, funct7, funct3, x1, x2)
//   out_valid/out_ready  result handshake (out, zero)
//   busy                 high while an iterative operation is in flight
module seq_alu #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       itype,
    input  logic [6:0]       funct7,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] x1,
    input  logic [WIDTH-1:0] x2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    localparam logic [2:0] IT_R = 3'b011, IT_I = 3'b001, IT_L = 3'b000,
                           IT_S = 3'b010, IT_B = 3'b110;
    localparam logic [6:0] F7_ALT = 7'b0100000, F7_M = 7'b0000001;

    state_t           state, state_nxt;
    logic [SHW-1:0]   cnt;
    logic [2:0]       op_f3;
    logic             neg_a, neg_b;      // operand signs (only set for signed ops)
    logic [WIDTH-1:0] op_b, op_x1;       // divisor/multiplicand magnitude, raw x1
    logic [WIDTH-1:0] acc_hi, acc_lo;    // mul: product hi/lo; div: remainder/quotient

    logic fire, is_m, last;
    assign fire = in_valid && in_ready;
    assign is_m = (itype == IT_R) && (funct7 == F7_M);
    assign last = (state != IDLE) && (cnt == SHW'(WIDTH - 1));

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (fire && is_m) state_nxt = funct3[2] ? DIV : MUL;
            MUL, DIV: if (last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state == IDLE) && (!out_valid || out_ready);
        busy     = (state != IDLE);
    end

    // ---------------- single-cycle datapath ----------------
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] alu_res;

    always_comb begin
        shamt   = x2[SHW-1:0];
        alu_res = '0;
        case (itype)
            IT_L, IT_S: alu_res = x1 + x2;
            IT_B:       alu_res = x1 - x2;
            IT_R, IT_I: begin
                if (funct7 == F7_ALT) begin
                    case (funct3)
                        3'b000:  alu_res = x1 - x2;
                        3'b101:  alu_res = $signed(x1) >>> shamt;
                        default: alu_res = '0;
                    endcase
                end else begin
                    // RTYPE with F7_M never lands here as a result (is_m path),
                    // ITYPE with F7_M intentionally decodes as the base set.
                    case (funct3)
                        3'b000:  alu_res = x1 + x2;
                        3'b001:  alu_res = x1 << shamt;
                        3'b010:  alu_res = {{(WIDTH-1){1'b0}}, $signed(x1) < $signed(x2)};
                        3'b011:  alu_res = {{(WIDTH-1){1'b0}}, x1 < x2};
                        3'b100:  alu_res = x1 ^ x2;
                        3'b101:  alu_res = x1 >> shamt;
                        3'b110:  alu_res = x1 | x2;
                        default: alu_res = x1 & x2;
                    endcase
                end
            end
            default: alu_res = '0;
        endcase
    end

    // ---------------- iterative datapath ----------------
    // Signedness of each operand per funct3 (MUL/MULH/DIV/REM both signed,
    // MULHSU signed x1 only, MULHU/DIVU/REMU unsigned).
    logic             sgn_a, sgn_b, in_neg_a, in_neg_b;
    logic [WIDTH-1:0] mag_a, mag_b;

    always_comb begin
        case (funct3)
            3'b011, 3'b101, 3'b111: sgn_a = 1'b0;
            default:                sgn_a = 1'b1;
        endcase
        case (funct3)
            3'b010, 3'b011, 3'b101, 3'b111: sgn_b = 1'b0;
            default:                        sgn_b = 1'b1;
        endcase
        in_neg_a = sgn_a && x1[WIDTH-1];
        in_neg_b = sgn_b && x2[WIDTH-1];
        mag_a    = in_neg_a ? -x1 : x1;
        mag_b    = in_neg_b ? -x2 : x2;
    end

    // One shift-add step: add multiplicand into the high half when the current
    // multiplier bit (lsb of lo) is set, then shift the whole product right.
    logic [WIDTH:0]   m_sum;
    logic [WIDTH-1:0] m_hi, m_lo;
    // One restoring step: shift next dividend bit into the remainder and
    // subtract the divisor if it fits. Remainder stays < divisor, so W bits hold it.
    logic [WIDTH:0]   d_sh, d_diff;
    logic             d_ge;
    logic [WIDTH-1:0] d_hi, d_lo;

    always_comb begin
        m_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, op_b} : '0);
        m_hi   = m_sum[WIDTH:1];
        m_lo   = {m_sum[0], acc_lo[WIDTH-1:1]};
        d_sh   = {acc_hi, acc_lo[WIDTH-1]};
        d_ge   = d_sh >= {1'b0, op_b};
        d_diff = d_sh - {1'b0, op_b};
        d_hi   = d_ge ? d_diff[WIDTH-1:0] : d_sh[WIDTH-1:0];
        d_lo   = {acc_lo[WIDTH-2:0], d_ge};
    end

    // Sign fix-up applied to the values produced by the final step.
    logic [2*WIDTH-1:0] prod, prod_s;
    logic [WIDTH-1:0]   mul_res, div_res, q_s, r_s, iter_res;

    always_comb begin
        prod    = {m_hi, m_lo};
        prod_s  = (neg_a ^ neg_b) ? -prod : prod;
        mul_res = (op_f3[1:0] == 2'b00) ? prod_s[WIDTH-1:0] : prod_s[2*WIDTH-1:WIDTH];
        q_s     = (neg_a ^ neg_b) ? -d_lo : d_lo;
        r_s     = neg_a ? -d_hi : d_hi;
        // op_b is a magnitude, so it is zero exactly when x2 was zero.
        if (op_b == '0) div_res = op_f3[1] ? op_x1 : '1;
        else            div_res = op_f3[1] ? r_s : q_s;
        iter_res = (state == MUL) ? mul_res : div_res;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            op_f3  <= '0;
            neg_a  <= 1'b0;
            neg_b  <= 1'b0;
            op_b   <= '0;
            op_x1  <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
        end else if (fire && is_m) begin
            cnt    <= '0;
            op_f3  <= funct3;
            neg_a  <= in_neg_a;
            neg_b  <= in_neg_b;
            op_b   <= mag_b;
            op_x1  <= x1;
            acc_hi <= '0;
            acc_lo <= mag_a;
        end else if (state != IDLE) begin
            cnt    <= last ? '0 : cnt + SHW'(1);
            acc_hi <= (state == MUL) ? m_hi : d_hi;
            acc_lo <= (state == MUL) ? m_lo : d_lo;
        end
    end

    // ---------------- output slot ----------------
    logic             load;
    logic [WIDTH-1:0] res_nxt;
    assign load    = (fire && !is_m) || last;
    assign res_nxt = last ? iter_res : alu_res;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out       <= '0;
            zero      <= 1'b1;
            out_valid <= 1'b0;
        end else if (load) begin
            out       <= res_nxt;
            zero      <= (res_nxt == '0);
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Directed-vector bench for seq_alu (WIDTH=32): table of ops with hand-computed
// results, then hand-written sequences for backpressure, back-to-back issue
// with same-edge consume/accept, and reset in the middle of a divide.
module tb_seq_alu;
    localparam int W = 32;
    localparam logic [2:0] R = 3'b011, I = 3'b001, LD = 3'b000, ST = 3'b010, BR = 3'b110;

    logic         clk = 1'b0, rst = 1'b1;
    logic         in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1, zero, busy;
    logic [2:0]   itype = '0, funct3 = '0;
    logic [6:0]   funct7 = '0;
    logic [W-1:0] x1 = '0, x2 = '0, out;

    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    seq_alu #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .itype(itype), .funct7(funct7), .funct3(funct3), .x1(x1), .x2(x2),
        .out_valid(out_valid), .out_ready(out_ready), .out(out), .zero(zero), .busy(busy)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, req);
        end
    endtask

    typedef struct {
        logic [2:0]   it;
        logic [6:0]   f7;
        logic [2:0]   f3;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        bit           iter;
    } vec_t;

    vec_t vt [32];

    // Issue one op at a negedge, then check result timing and value.
    task automatic run_op(input vec_t v, input int idx);
        int g, k, bc;
        g = 0;
        while (!in_ready && g < 100) begin @(negedge clk); g++; end
        chk($sformatf("v%0d_in_ready", idx), in_ready, 1);
        itype = v.it; funct7 = v.f7; funct3 = v.f3; x1 = v.a; x2 = v.b; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; x1 = $urandom; x2 = $urandom;
        if (v.iter) begin
            k = 0; bc = 0;
            while (!out_valid && k < 100) begin
                if (busy) bc++;
                @(negedge clk);
                k++;
            end
            chk($sformatf("v%0d_latency", idx), k, W);
            chk($sformatf("v%0d_busy_cycles", idx), bc, W);
            chk($sformatf("v%0d_busy_done", idx), busy, 0);
        end
        chk($sformatf("v%0d_out_valid", idx), out_valid, 1);
        chk($sformatf("v%0d_out", idx), out, v.res);
        chk($sformatf("v%0d_zero", idx), zero, (v.res == '0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int k;
        // single-cycle
        vt[0]  = '{I,  7'h00, 3'b000, 32'd5,        32'hFFFFFFF9, 32'hFFFFFFFE, 1'b0};
        vt[1]  = '{LD, 7'h00, 3'b000, 32'h10,       32'hFFFFFFF0, 32'h0,        1'b0};
        vt[2]  = '{R,  7'h20, 3'b101, 32'h80000000, 32'h24,       32'hF8000000, 1'b0};
        vt[3]  = '{ST, 7'h00, 3'b000, 32'd1,        32'd2,        32'd3,        1'b0};
        vt[4]  = '{BR, 7'h00, 3'b000, 32'd3,        32'd5,        32'hFFFFFFFE, 1'b0};
        vt[5]  = '{3'b111, 7'h00, 3'b000, 32'd3,    32'd5,        32'h0,        1'b0};
        vt[6]  = '{R,  7'h20, 3'b000, 32'd10,       32'd3,        32'd7,        1'b0};
        vt[7]  = '{R,  7'h20, 3'b010, 32'd10,       32'd3,        32'h0,        1'b0};
        vt[8]  = '{R,  7'h00, 3'b001, 32'd1,        32'h21,       32'd2,        1'b0};
        vt[9]  = '{R,  7'h00, 3'b010, 32'hFFFFFFFF, 32'd1,        32'd1,        1'b0};
        vt[10] = '{R,  7'h00, 3'b011, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b0};
        vt[11] = '{R,  7'h00, 3'b100, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0};
        vt[12] = '{I,  7'h00, 3'b101, 32'h80000000, 32'd4,        32'h08000000, 1'b0};
        vt[13] = '{R,  7'h00, 3'b110, 32'h0F0,      32'h00F,      32'h0FF,      1'b0};
        vt[14] = '{R,  7'h00, 3'b111, 32'hF0F0,     32'hFF00,     32'hF000,     1'b0};
        vt[15] = '{I,  7'h01, 3'b000, 32'd5,        32'd6,        32'd11,       1'b0};
        vt[16] = '{I,  7'h01, 3'b011, 32'd1,        32'd2,        32'd1,        1'b0};
        vt[17] = '{R,  7'h03, 3'b000, 32'hFFFFFFFF, 32'd1,        32'h0,        1'b0};
        // iterative
        vt[18] = '{R,  7'h01, 3'b001, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 1'b1};
        vt[19] = '{R,  7'h01, 3'b000, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFA, 1'b1};
        vt[20] = '{R,  7'h01, 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b1};
        vt[21] = '{R,  7'h01, 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1};
        vt[22] = '{R,  7'h01, 3'b100, 32'd7,        32'd0,        32'hFFFFFFFF, 1'b1};
        vt[23] = '{R,  7'h01, 3'b110, 32'd7,        32'd0,        32'd7,        1'b1};
        vt[24] = '{R,  7'h01, 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1};
        vt[25] = '{R,  7'h01, 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h0,        1'b1};
        vt[26] = '{R,  7'h01, 3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b1};
        vt[27] = '{R,  7'h01, 3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 1'b1};
        vt[28] = '{R,  7'h01, 3'b101, 32'd100,      32'd7,        32'd14,       1'b1};
        vt[29] = '{R,  7'h01, 3'b111, 32'd100,      32'd7,        32'd2,        1'b1};
        vt[30] = '{R,  7'h01, 3'b000, 32'h10000,    32'h10000,    32'h0,        1'b1};
        vt[31] = '{R,  7'h01, 3'b111, 32'd5,        32'd0,        32'd5,        1'b1};

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_out", out, 0);
        chk("rst_zero", zero, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 1);
        rst = 1'b0;

        for (int i = 0; i < 32; i++) run_op(vt[i], i);

        // backpressure: result held, input stalled; pending op accepted on the
        // same edge the held result is consumed
        @(negedge clk);
        out_ready = 1'b0;
        itype = R; funct7 = 7'h00; funct3 = 3'b000; x1 = 32'd2; x2 = 32'd3; in_valid = 1'b1;
        @(negedge clk);
        x1 = 32'd9; x2 = 32'd1;
        for (int i = 0; i < 6; i++) begin
            chk("hold_out", out, 5);
            chk("hold_valid", out_valid, 1);
            chk("hold_in_ready", in_ready, 0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("drain_accept_out", {out_valid, out}, {1'b1, 32'd10});

        // back-to-back single-cycle ops
        for (int i = 0; i < 10; i++) begin
            itype = R; funct7 = 7'h00; funct3 = 3'b000; x1 = i; x2 = 32'd100; in_valid = 1'b1;
            @(negedge clk);
            chk($sformatf("b2b_%0d", i), {out_valid, out}, {1'b1, 32'(i + 100)});
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("b2b_drained", out_valid, 0);

        // reset mid DIVU
        itype = R; funct7 = 7'h01; funct3 = 3'b101; x1 = 32'd100; x2 = 32'd7; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        chk("mid_busy", busy, 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_out", out, 0);
        chk("arst_zero", zero, 1);
        chk("arst_valid", out_valid, 0);
        chk("arst_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        k = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid || busy) k++;
        end
        chk("post_rst_quiet", k, 0);

        run_op('{LD, 7'h00, 3'b000, 32'd7, 32'd8, 32'd15, 1'b0}, 99);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
